// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: exception source codes, interrupt controller states
// and the lowest-index priority helper.
package cp0_pkg;

  localparam int MAX_IRQ = 8;

  localparam logic [2:0] EXP_NONE    = 3'b000;
  localparam logic [2:0] EXP_SYSCALL = 3'b001;
  localparam logic [2:0] EXP_INT     = 3'b100;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  // Lowest set bit wins; returns 0 for an empty vector.
  function automatic logic [2:0] lowest_set(input logic [MAX_IRQ-1:0] vec);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = MAX_IRQ - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/cp0_irq_ctrl_if.sv
// CP0-facing bundle of the interrupt controller: mask write path, request/ack
// handshake and status readback.
interface cp0_irq_ctrl_if #(
  parameter int NUM_IRQ = 6
);
  logic               mask_we;
  logic [NUM_IRQ-1:0] mask_wdata;
  logic               exp_ack;
  logic               eret;
  logic               exp_req;
  logic [2:0]         exp_src;
  logic [2:0]         irq_id;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] mask;
  logic               in_service;

  modport master (
    output mask_we, mask_wdata, exp_ack, eret,
    input  exp_req, exp_src, irq_id, pending, mask, in_service
  );

  modport slave (
    input  mask_we, mask_wdata, exp_ack, eret,
    output exp_req, exp_src, irq_id, pending, mask, in_service
  );
endinterface

// File: rtl/cp0_irq_ctrl_sync_edge.sv
// One interrupt line: multi-flop synchroniser followed by a rising-edge
// detector whose pulse lasts one cycle.
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic irq_async,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   hist_q;
  logic                   hist_d;

  // Shift the raw line in at the bottom; history holds the last synchronised value.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], irq_async};
    hist_d = sync_q[SYNC_STAGES-1];
  end

  // Synchroniser and edge-history flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{1'b0}};
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/cp0_irq_ctrl.sv
// Interrupt source for CP0: synchronises external lines, tracks pending/mask
// state and raises one prioritised request, blocking further ones until eret.
module cp0_irq_ctrl
  import cp0_pkg::*;
#(
  parameter int         NUM_IRQ     = 6,
  parameter logic [2:0] INT_CODE    = EXP_INT,
  parameter int         SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  cp0_irq_ctrl_if.slave      bus
);

  irq_state_e         state_q, state_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [2:0]         irq_id_q, irq_id_d;
  logic               exp_req_q, exp_req_d;
  logic [2:0]         exp_src_q, exp_src_d;
  logic               in_service_q, in_service_d;

  logic [NUM_IRQ-1:0] edge_set;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] id_hit;
  logic [NUM_IRQ-1:0] ack_clr;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
    irq_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .irq_async(irq_in[g]),
      .rise     (edge_set[g])
    );
  end

  // Next-state logic: handshake FSM, pending set/clear and mask update.
  always_comb begin
    state_d      = state_q;
    irq_id_d     = irq_id_q;
    exp_req_d    = exp_req_q;
    exp_src_d    = exp_src_q;
    in_service_d = in_service_q;
    ack_clr      = {NUM_IRQ{1'b0}};
    eligible     = pending_q & mask_q;
    for (int i = 0; i < NUM_IRQ; i++) begin
      id_hit[i] = (irq_id_q == 3'(i));
    end
    mask_d = bus.mask_we ? bus.mask_wdata : mask_q;

    case (state_q)
      IDLE: begin
        if (|eligible) begin
          state_d   = REQ;
          irq_id_d  = lowest_set(MAX_IRQ'(eligible));
          exp_req_d = 1'b1;
          exp_src_d = INT_CODE;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        // Ack beats a same-cycle mask clear: CP0 has already committed to the request.
        if (bus.exp_ack) begin
          ack_clr      = id_hit;
          state_d      = SERVICE;
          in_service_d = 1'b1;
          exp_req_d    = 1'b0;
          exp_src_d    = EXP_NONE;
        end else if (~|(mask_q & id_hit)) begin
          state_d   = IDLE;
          exp_req_d = 1'b0;
          exp_src_d = EXP_NONE;
        end else begin
          state_d = REQ;
        end
      end
      SERVICE: begin
        if (bus.eret) begin
          state_d      = IDLE;
          in_service_d = 1'b0;
        end else begin
          state_d = SERVICE;
        end
      end
      default: begin
        state_d      = IDLE;
        exp_req_d    = 1'b0;
        exp_src_d    = EXP_NONE;
        in_service_d = 1'b0;
      end
    endcase

    // A fresh edge on the line being acked must survive the clear.
    pending_d = (pending_q & ~ack_clr) | edge_set;
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pending_q    <= {NUM_IRQ{1'b0}};
      mask_q       <= {NUM_IRQ{1'b0}};
      irq_id_q     <= 3'd0;
      exp_req_q    <= 1'b0;
      exp_src_q    <= EXP_NONE;
      in_service_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      irq_id_q     <= irq_id_d;
      exp_req_q    <= exp_req_d;
      exp_src_q    <= exp_src_d;
      in_service_q <= in_service_d;
    end
  end

  assign bus.exp_req    = exp_req_q;
  assign bus.exp_src    = exp_src_q;
  assign bus.irq_id     = irq_id_q;
  assign bus.pending    = pending_q;
  assign bus.mask       = mask_q;
  assign bus.in_service = in_service_q;

endmodule
